shift_issue_stage: RTL and testbench

- ID/EX pipeline stage that sits directly upstream of the barrel shifter.
- Accepts decoded R-type instruction words with their register operands and keeps only the six MIPS shift instructions: SLL, SRL, SRA, SLLV, SRLV, SRAV.
- For each one it selects the shift amount, forms the shifter's 2-bit operation code and registers the operands.
- Presents the result to the shifter and writeback through a 2-entry skid buffer with a valid/ready handshake, flush and drop accounting.

---
 rtl/shift_issue_stage_if.sv | 30 +++
 rtl/shift_issue_stage.sv | 113 +++++++++++
 tb/tb_shift_issue_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_issue_stage_if.sv
// Handshake bus around the shift issue stage.
//   Upstream side  : in_valid/in_ready with instr, rs_data, rt_data.
//   Downstream side: out_valid/out_ready with the sh_* shifter fields.
// modport slave  : the stage's own view.
// modport master : the environment's view (decoder plus shifter/writeback).
interface shift_issue_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sh_a;
    logic [31:0] sh_b;
    logic        sh_aluc1;
    logic        sh_aluc0;
    logic [4:0]  sh_rd;
    logic        sh_wen;

    modport slave (
        input  in_valid, instr, rs_data, rt_data, out_ready,
        output in_ready, out_valid, sh_a, sh_b, sh_aluc1, sh_aluc0, sh_rd, sh_wen
    );

    modport master (
        output in_valid, instr, rs_data, rt_data, out_ready,
        input  in_ready, out_valid, sh_a, sh_b, sh_aluc1, sh_aluc0, sh_rd, sh_wen
    );
endinterface

// File: rtl/shift_issue_stage.sv
// ID/EX stage ahead of the barrel shifter. It filters R-type words down to the
// six MIPS shifts, picks the shift amount, forms the 2-bit shifter opcode and
// hands the result on through a 2-entry skid buffer.
//   clk, rst  : clock, synchronous active-high reset (beats flush)
//   flush     : empties both entries; a word accepted in that cycle is lost
//   bus       : in_* upstream handshake, out_* / sh_* downstream handshake
//   drop_cnt  : saturating count of discarded non-shift words
module shift_issue_stage #(
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    shift_issue_stage_if.slave    bus,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [4:0]  rd;
        logic        wen;
    } sh_entry_t;

    sh_entry_t             r_main, r_skid, w_new;
    logic                  r_main_vld, r_skid_vld;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic       w_is_shift, w_use_rs, w_acc, w_push, w_drop, w_pop;
    logic [1:0] w_op;
    logic       w_unused_bits;

    // rs/rt field numbers and the high bits of rs_data play no part here.
    assign w_unused_bits = ^{bus.instr[25:16], bus.rs_data[31:5]};

    always_comb begin
        w_is_shift = 1'b0;
        w_use_rs   = 1'b0;
        w_op       = 2'b10;
        if (bus.instr[31:26] == 6'd0) begin
            case (bus.instr[5:0])
                6'b000000: begin w_is_shift = 1'b1; w_op = 2'b10; end
                6'b000010: begin w_is_shift = 1'b1; w_op = 2'b01; end
                6'b000011: begin w_is_shift = 1'b1; w_op = 2'b00; end
                6'b000100: begin w_is_shift = 1'b1; w_op = 2'b10; w_use_rs = 1'b1; end
                6'b000110: begin w_is_shift = 1'b1; w_op = 2'b01; w_use_rs = 1'b1; end
                6'b000111: begin w_is_shift = 1'b1; w_op = 2'b00; w_use_rs = 1'b1; end
                default:   w_is_shift = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_new.a   = {27'd0, (w_use_rs ? bus.rs_data[4:0] : bus.instr[10:6])};
        w_new.b   = bus.rt_data;
        w_new.op  = w_op;
        w_new.rd  = bus.instr[15:11];
        w_new.wen = (bus.instr[15:11] != 5'd0);
    end

    // in_ready depends only on the registered skid flag, never on out_ready.
    assign w_acc  = bus.in_valid && !r_skid_vld;
    assign w_push = w_acc && w_is_shift && !flush;
    assign w_drop = w_acc && !w_is_shift && !flush;
    assign w_pop  = r_main_vld && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (flush) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (w_pop) begin
            if (r_skid_vld) begin
                r_main     <= r_skid;
                r_main_vld <= 1'b1;
                r_skid_vld <= w_push;
                if (w_push) r_skid <= w_new;
            end else begin
                r_main_vld <= w_push;
                if (w_push) r_main <= w_new;
            end
        end else if (!r_main_vld) begin
            r_main_vld <= w_push;
            if (w_push) r_main <= w_new;
        end else if (w_push) begin
            r_skid     <= w_new;
            r_skid_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_drop_cnt <= '0;
        else if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}}))
            r_drop_cnt <= r_drop_cnt + 1'b1;
    end

    assign bus.in_ready  = !r_skid_vld;
    assign bus.out_valid = r_main_vld;
    assign bus.sh_a      = r_main.a;
    assign bus.sh_b      = r_main.b;
    assign bus.sh_aluc1  = r_main.op[1];
    assign bus.sh_aluc0  = r_main.op[0];
    assign bus.sh_rd     = r_main.rd;
    assign bus.sh_wen    = r_main.wen;
    assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_shift_issue_stage.sv
module tb_shift_issue_stage;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] drop_cnt;

    shift_issue_stage_if bus();

    shift_issue_stage #(.DROP_CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus.slave),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // {sh_a, sh_b, aluc, rd, wen}
    typedef logic [71:0] exp_t;
    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string nm, input bit ok, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic exp_t cur_out();
        return {bus.sh_a, bus.sh_b, bus.sh_aluc1, bus.sh_aluc0, bus.sh_rd, bus.sh_wen};
    endfunction

    // Monitor: pops the scoreboard on each transfer, and checks hold-stability.
    exp_t snap;
    bit   was_stall = 1'b0;
    always @(negedge clk) begin
        exp_t got, e;
        if (!rst) begin
            got = cur_out();
            if (was_stall) begin
                chk("stall_hold", bus.out_valid && got == snap, {23'd0, bus.out_valid, got}, {23'd0, 1'b1, snap});
            end
            if (bus.out_valid && bus.out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1'b0, {24'd0, got}, 96'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_fields", got == e, {24'd0, got}, {24'd0, e});
                end
            end
            was_stall = bus.out_valid && !bus.out_ready && !flush;
            snap      = got;
        end else begin
            was_stall = 1'b0;
        end
    end

    // Present one word and wait (bounded) for it to be accepted.
    task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                        input bit exp_out, input logic [31:0] ea, input logic [1:0] eop,
                        input logic [4:0] erd, input bit ewen);
        bit acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.rs_data  = rs;
        bus.rt_data  = rt;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 1'b0, 96'd0, 96'd1);
        else if (exp_out) exp_q.push_back({ea, rt, eop, erd, ewen});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.rs_data   = '0;
        bus.rt_data   = '0;
        bus.out_ready = 1'b1;

        // Reset values
        @(posedge clk); @(negedge clk);
        chk("rst_out_valid", bus.out_valid == 1'b0, {95'd0, bus.out_valid}, 96'd0);
        chk("rst_in_ready", bus.in_ready == 1'b1, {95'd0, bus.in_ready}, 96'd1);
        chk("rst_drop_cnt", drop_cnt == 8'd0, {88'd0, drop_cnt}, 96'd0);
        chk("rst_sh", cur_out() == '0, {24'd0, cur_out()}, 96'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1);

        // SRA rd3, rt2, sa2 with one-cycle latency
        send(32'h00021883, 32'h0, 32'h80000010, 1'b1, 32'h2, 2'b00, 5'd3, 1'b1);
        @(negedge clk);
        chk("latency_1", bus.out_valid == 1'b1, {95'd0, bus.out_valid}, 96'd1);
        @(posedge clk); #1;

        // SLLV rd6, rt5, rs4 ; SRLV variant
        send(32'h00853004, 32'hFFFFFFE3, 32'h12345678, 1'b1, 32'h3, 2'b10, 5'd6, 1'b1);
        send(32'h00853006, 32'h0000002A, 32'h87654321, 1'b1, 32'hA, 2'b01, 5'd6, 1'b1);
        cyc(2);

        // Backpressure: rd=1,2,3 SLL back to back with out_ready low
        bus.out_ready = 1'b0;
        send(32'h00020840, 32'h0, 32'h0000000F, 1'b1, 32'h1, 2'b10, 5'd1, 1'b1);
        send(32'h00021080, 32'h0, 32'h0000000F, 1'b1, 32'h2, 2'b10, 5'd2, 1'b1);
        @(negedge clk);
        chk("bp_in_ready_low", bus.in_ready == 1'b0, {95'd0, bus.in_ready}, 96'd0);
        @(posedge clk); #1;
        fork
            send(32'h000218C0, 32'h0, 32'h0000000F, 1'b1, 32'h3, 2'b10, 5'd3, 1'b1);
            begin
                cyc(3);
                bus.out_ready = 1'b1;
            end
        join
        cyc(3);
        chk("bp_drained", exp_q.size() == 0, exp_q.size(), 96'd0);

        // Discards: addi and syscall
        send(32'h20010005, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 5'd0, 1'b0);
        @(negedge clk);
        chk("drop_addi", drop_cnt == 8'd1, {88'd0, drop_cnt}, 96'd1);
        @(posedge clk); #1;
        send(32'h0000000C, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 5'd0, 1'b0);
        @(negedge clk);
        chk("drop_syscall", drop_cnt == 8'd2, {88'd0, drop_cnt}, 96'd2);
        @(posedge clk); #1;

        // Flush with both entries full and a word offered
        bus.out_ready = 1'b0;
        send(32'h00020840, 32'h0, 32'h1, 1'b0, 32'h0, 2'b00, 5'd0, 1'b0);
        send(32'h00021080, 32'h0, 32'h2, 1'b0, 32'h0, 2'b00, 5'd0, 1'b0);
        bus.in_valid = 1'b1;
        bus.instr    = 32'h000218C0;
        flush        = 1'b1;
        cyc(1);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_full_state", {bus.out_valid, bus.in_ready} == 2'b01,
            {94'd0, bus.out_valid, bus.in_ready}, 96'd1);
        chk("flush_drop_keep", drop_cnt == 8'd2, {88'd0, drop_cnt}, 96'd2);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;

        // Flush on an empty stage: shift and non-shift accepted in the flush cycle
        bus.in_valid = 1'b1;
        bus.instr    = 32'h00021883;
        flush        = 1'b1;
        cyc(1);
        bus.instr = 32'h0000000C;
        cyc(1);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        cyc(2);
        chk("flush_accept_nodrop", drop_cnt == 8'd2, {88'd0, drop_cnt}, 96'd2);
        chk("flush_no_out", bus.out_valid == 1'b0, {95'd0, bus.out_valid}, 96'd0);

        // NOP is a legal SLL with wen=0
        send(32'h00000000, 32'hFFFFFFFF, 32'hCAFEF00D, 1'b1, 32'h0, 2'b10, 5'd0, 1'b0);
        cyc(2);

        // Saturation
        for (int i = 0; i < 300; i++)
            send(32'h0000000C, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 5'd0, 1'b0);
        @(negedge clk);
        chk("drop_saturate", drop_cnt == 8'd255, {88'd0, drop_cnt}, 96'd255);
        @(posedge clk); #1;

        // Reset together with flush while holding data
        bus.out_ready = 1'b0;
        send(32'h00021883, 32'h0, 32'h55, 1'b0, 32'h0, 2'b00, 5'd0, 1'b0);
        rst   = 1'b1;
        flush = 1'b1;
        cyc(1);
        rst   = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("rst_flush_state", {bus.out_valid, bus.in_ready} == 2'b01,
            {94'd0, bus.out_valid, bus.in_ready}, 96'd1);
        chk("rst_flush_cnt", drop_cnt == 8'd0, {88'd0, drop_cnt}, 96'd0);
        chk("rst_flush_sh", cur_out() == '0, {24'd0, cur_out()}, 96'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        cyc(3);

        chk("scoreboard_empty", exp_q.size() == 0, exp_q.size(), 96'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
